uart_rx_ctrl: RTL

- Receive-path controller between the UART receiver and the byte consumer (CPU/register interface).
- Detects completed frames from the receiver, buffers each byte with its error flags in a small first-word-fall-through (FWFT) FIFO, and presents entries through a valid/ready handshake.
- Sequences enable/drain/flush and keeps saturating overrun, parity-error and stop-error statistics.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 74 +++++++
 rtl/uart_rx_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-path controller.
// Latency: none (types, constants and a packing helper only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int RX_ENTRY_W = 10;

    // Bit positions of the error flags within out_err
    localparam int ERR_PAR  = 0;
    localparam int ERR_STOP = 1;

    typedef enum logic [1:0] {
        CTRL_DISABLED = 2'd0,
        CTRL_ACTIVE   = 2'd1,
        CTRL_DRAIN    = 2'd2
    } ctrl_state_e;

    // FIFO entry layout: {stop_err, parity_err, data}
    function automatic logic [RX_ENTRY_W-1:0] pack_entry(
        input logic [DATA_W-1:0] data,
        input logic              parity_err,
        input logic              stop_err
    );
        return {stop_err, parity_err, data};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received frames.
// Latency: a write is visible at rd_data the cycle after the write edge.
// Backpressure: writes when full are dropped unless a read happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    // Head is masked to zero when empty so stale storage never leaks out
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Flush wins over both ports; a full FIFO still accepts a write alongside a read
    assign do_rd = rd_en & ~empty & ~flush;
    assign do_wr = wr_en & (~full | do_rd) & ~flush;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_wr && !do_rd) count_d = count_q + 1'b1;
            if (do_rd && !do_wr) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while not covered by the pointers
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-path controller: frame edge detect, enable/drain/flush sequencing, error statistics.
// Latency: a frame event at edge N is presented on out_valid/out_data after edge N.
// Backpressure: valid/ready on the output; frames arriving to a full FIFO are counted as overruns.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8,
    parameter int DROP_ERR = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_en,
    input  logic                       flush,
    input  logic                       clr_stats,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_parity_err,
    input  logic                       rx_stop_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [1:0]                 out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_full,
    output logic [CNT_W-1:0]           overrun_cnt,
    output logic [CNT_W-1:0]           parity_err_cnt,
    output logic [CNT_W-1:0]           stop_err_cnt
);

    ctrl_state_e             state_q, state_d;
    logic                    rx_valid_q;
    logic [CNT_W-1:0]        ovr_cnt_q, ovr_cnt_d;
    logic [CNT_W-1:0]        par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0]        stop_cnt_q, stop_cnt_d;
    logic [RX_ENTRY_W-1:0]   head;
    logic                    fifo_empty;
    logic                    frame_evt, accept, drop_frame, rd, wr_en, overrun;

    // A held rx_valid yields exactly one event on its rising edge
    assign frame_evt  = rx_valid & ~rx_valid_q;
    assign accept     = (state_q == CTRL_ACTIVE) & frame_evt & ~flush;
    assign drop_frame = (DROP_ERR != 0) & (rx_parity_err | rx_stop_err);
    assign rd         = out_valid & out_ready & ~flush;
    assign wr_en      = accept & ~drop_frame & (~fifo_full | rd);
    assign overrun    = accept & ~drop_frame & fifo_full & ~rd;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (pack_entry(rx_data, rx_parity_err, rx_stop_err)),
        .rd_en   (rd),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_err   = head[RX_ENTRY_W-1:DATA_W];

    assign overrun_cnt    = ovr_cnt_q;
    assign parity_err_cnt = par_cnt_q;
    assign stop_err_cnt   = stop_cnt_q;

    // Controller next state; flush overrides the normal transitions
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CTRL_DISABLED: if (rx_en) state_d = CTRL_ACTIVE;
            CTRL_ACTIVE:   if (!rx_en) state_d = fifo_empty ? CTRL_DISABLED : CTRL_DRAIN;
            CTRL_DRAIN: begin
                if (rx_en)           state_d = CTRL_ACTIVE;
                else if (fifo_empty) state_d = CTRL_DISABLED;
            end
            default:       state_d = CTRL_DISABLED;
        endcase
        if (flush) state_d = rx_en ? CTRL_ACTIVE : CTRL_DISABLED;
    end

    // Saturating statistics; a clear discards any same-cycle increment
    always_comb begin
        ovr_cnt_d  = ovr_cnt_q;
        par_cnt_d  = par_cnt_q;
        stop_cnt_d = stop_cnt_q;
        if (clr_stats) begin
            ovr_cnt_d  = '0;
            par_cnt_d  = '0;
            stop_cnt_d = '0;
        end else begin
            if (accept && rx_parity_err && par_cnt_q != '1)  par_cnt_d  = par_cnt_q + 1'b1;
            if (accept && rx_stop_err && stop_cnt_q != '1)   stop_cnt_d = stop_cnt_q + 1'b1;
            if (overrun && ovr_cnt_q != '1)                  ovr_cnt_d  = ovr_cnt_q + 1'b1;
        end
    end

    // State, edge-detect and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= CTRL_DISABLED;
            rx_valid_q <= 1'b0;
            ovr_cnt_q  <= '0;
            par_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rx_valid;
            ovr_cnt_q  <= ovr_cnt_d;
            par_cnt_q  <= par_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

endmodule
